// File: rtl/lab1_normalize_if.sv
// Handshake and result bundle between the sample source, lab1_normalize and the rounding stage.
interface lab1_normalize_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] D;
  logic        out_valid;
  logic        out_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        Fifth;

  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, S, E, F, Fifth
  );

  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, S, E, F, Fifth
  );
endinterface

// File: rtl/lab1_normalize.sv
// Sequential front end of the 12-bit two's-complement to float converter:
// sign-magnitude conversion, then iterative leading-zero normalisation one shift per clock.
module lab1_normalize (
  input logic             clk,
  input logic             rst_n,
  lab1_normalize_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [11:0] d_q, d_d;
  logic [11:0] w_q, w_d;
  logic [3:0]  lz_q, lz_d;
  logic        s_q, s_d;
  logic [2:0]  e_q, e_d;
  logic [3:0]  f_q, f_d;
  logic        fifth_q, fifth_d;

  logic [11:0] mag;
  logic        lz_full;

  // -2048 has no positive 12-bit counterpart, so it saturates to +2047.
  always_comb begin
    mag = d_q;
    if (d_q[11]) begin
      if (d_q == 12'h800) begin
        mag = 12'h7FF;
      end else begin
        mag = ~d_q + 12'd1;
      end
    end
  end

  assign lz_full = (lz_q == 4'd8);

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    w_d     = w_q;
    lz_d    = lz_q;
    s_d     = s_q;
    e_d     = e_q;
    f_d     = f_q;
    fifth_d = fifth_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          d_d     = bus.D;
          state_d = CONV;
        end
      end
      CONV: begin
        w_d     = mag;
        s_d     = d_q[11];
        lz_d    = 4'd1;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Once lz reaches 8 the exponent bottoms out at 0 and F is the raw low nibble.
        if (w_q[10] || lz_full) begin
          e_d     = lz_full ? 3'd0 : 3'(4'd8 - lz_q);
          f_d     = w_q[10:7];
          fifth_d = w_q[6];
          state_d = OUT;
        end else begin
          w_d  = w_q << 1;
          lz_d = lz_q + 4'd1;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      w_q     <= '0;
      lz_q    <= '0;
      s_q     <= 1'b0;
      e_q     <= '0;
      f_q     <= '0;
      fifth_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      w_q     <= w_d;
      lz_q    <= lz_d;
      s_q     <= s_d;
      e_q     <= e_d;
      f_q     <= f_d;
      fifth_q <= fifth_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.S         = s_q;
  assign bus.E         = e_q;
  assign bus.F         = f_q;
  assign bus.Fifth     = fifth_q;

endmodule

// File: tb/tb_lab1_normalize.sv
// Directed, table-driven bench for lab1_normalize with backpressure and mid-conversion reset sequences.
module tb_lab1_normalize;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  lab1_normalize_if bus ();

  lab1_normalize dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic        fifth;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; leaves the DUT idle again.
  task automatic apply(input vec_t v);
    int lat;
    bit got;
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.D        = v.d;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.D        = 12'hA5C;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (!got) begin
        @(posedge clk); #1;
        lat = i;
        if (bus.out_valid) got = 1'b1;
      end
    end
    chk($sformatf("latency_%03h", v.d), got ? lat : -1, v.lat);
    chk($sformatf("S_%03h", v.d), int'(bus.S), int'(v.s));
    chk($sformatf("E_%03h", v.d), int'(bus.E), int'(v.e));
    chk($sformatf("F_%03h", v.d), int'(bus.F), int'(v.f));
    chk($sformatf("Fifth_%03h", v.d), int'(bus.Fifth), int'(v.fifth));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk($sformatf("post_hs_in_ready_%03h", v.d), int'(bus.in_ready), 1);
    chk($sformatf("post_hs_out_valid_%03h", v.d), int'(bus.out_valid), 0);
    chk($sformatf("post_hs_E_held_%03h", v.d), int'(bus.E), int'(v.e));
  endtask

  initial begin
    bit seen;
    pass_cnt      = 0;
    total_cnt     = 0;
    bus.in_valid  = 1'b0;
    bus.D         = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    vecs[0]  = '{d: 12'h000, s: 1'b0, e: 3'd0, f: 4'h0, fifth: 1'b0, lat: 9};
    vecs[1]  = '{d: 12'h800, s: 1'b1, e: 3'd7, f: 4'hF, fifth: 1'b1, lat: 2};
    vecs[2]  = '{d: 12'h07D, s: 1'b0, e: 3'd3, f: 4'hF, fifth: 1'b1, lat: 6};
    vecs[3]  = '{d: 12'hFFF, s: 1'b1, e: 3'd0, f: 4'h1, fifth: 1'b0, lat: 9};
    vecs[4]  = '{d: 12'h0A6, s: 1'b0, e: 3'd4, f: 4'hA, fifth: 1'b0, lat: 5};
    vecs[5]  = '{d: 12'h7FF, s: 1'b0, e: 3'd7, f: 4'hF, fifth: 1'b1, lat: 2};
    vecs[6]  = '{d: 12'h001, s: 1'b0, e: 3'd0, f: 4'h1, fifth: 1'b0, lat: 9};
    vecs[7]  = '{d: 12'h010, s: 1'b0, e: 3'd1, f: 4'h8, fifth: 1'b0, lat: 8};
    vecs[8]  = '{d: 12'h00F, s: 1'b0, e: 3'd0, f: 4'hF, fifth: 1'b0, lat: 9};
    vecs[9]  = '{d: 12'h801, s: 1'b1, e: 3'd7, f: 4'hF, fifth: 1'b1, lat: 2};
    vecs[10] = '{d: 12'hF00, s: 1'b1, e: 3'd5, f: 4'h8, fifth: 1'b0, lat: 4};
    vecs[11] = '{d: 12'h3C0, s: 1'b0, e: 3'd6, f: 4'hF, fifth: 1'b0, lat: 3};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_S", int'(bus.S), 0);
    chk("rst_E", int'(bus.E), 0);
    chk("rst_F", int'(bus.F), 0);
    chk("rst_Fifth", int'(bus.Fifth), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
    end

    // Backpressure: result held 5 cycles with out_ready low and a competing sample offered.
    bus.D        = 12'h0A6;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.D = 12'h800;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (bus.out_valid) seen = 1'b1;
      end
    end
    chk("bp_out_valid_seen", int'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_S", int'(bus.S), 0);
      chk("bp_E", int'(bus.E), 4);
      chk("bp_F", int'(bus.F), 4'hA);
      chk("bp_Fifth", int'(bus.Fifth), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_hs_in_ready", int'(bus.in_ready), 1);
    chk("bp_hs_out_valid", int'(bus.out_valid), 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset asserted while D=001 is still shifting; prior outputs are nonzero (E=4, F=A).
    bus.D        = 12'h001;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_E", int'(bus.E), 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_S", int'(bus.S), 0);
    chk("midrst_E", int'(bus.E), 0);
    chk("midrst_F", int'(bus.F), 0);
    chk("midrst_Fifth", int'(bus.Fifth), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_output", int'(seen), 0);

    apply(vecs[2]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
